mem_unit: RTL
=============

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 parameter MEM_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-002 parameter CLKS_PER_BIT, default 16, UART bit period in clk cycles (>=2).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  reset rst, asynchronous, active-high.
REQ-005 bus  inout  32  shared CPU data/address bus.
REQ-006 mem_load  input  1  latch bus into address register.
REQ-007 mem_rd  input  1  drive addressed read data onto bus.
REQ-008 mem_wr  input  1  write bus value to addressed location.
REQ-009 uart_txd  output  1  UART serial out, idle high.
REQ-010 fault  output  1  sticky misaligned-access flag.

Function
REQ-011 Address register SHALL load bus on rising clk when mem_load=1.
REQ-012 Memory map SHALL be: RAM at 0x0000_0000..4*MEM_WORDS-1; UART DATA 0x8000_0000; UART STATUS 0x8000_0004; all else unmapped.
REQ-013 While mem_rd=1 and mem_wr=0, bus SHALL be driven combinationally (same cycle, no latency) with read data; otherwise bus SHALL be high-impedance.
REQ-014 Read data: RAM word at addr[log2(MEM_WORDS)+1:2]; STATUS = {31'b0, busy}; DATA and unmapped = 0.
REQ-015 On rising clk with mem_wr=1: RAM word SHALL take bus; DATA write with busy=0 SHALL start a frame of bus[7:0]; DATA write with busy=1, STATUS and unmapped writes SHALL be ignored.
REQ-016 Access with addr[1:0]!=0 (mem_rd or mem_wr) SHALL set fault, drive 0 on read, suppress write; fault SHALL clear only on reset.
REQ-017 mem_load and mem_wr same cycle: write SHALL use old address; register then updates.
REQ-018 mem_rd and mem_wr same cycle: write SHALL occur, bus SHALL not be driven.
REQ-019 UART FSM states IDLE, START, DATA, STOP; busy=1 in all but IDLE.
REQ-020 IDLE->START on accepted DATA write: txd=0 for CLKS_PER_BIT cycles; START->DATA: 8 bits LSB first, CLKS_PER_BIT each; DATA->STOP after bit 7; STOP: txd=1 for CLKS_PER_BIT; STOP->IDLE.
REQ-021 First start-bit cycle SHALL be the cycle after the accepting clk edge; busy SHALL read 1 from that cycle until return to IDLE.
REQ-022 Baud counter and bit index SHALL wrap to 0 at each bit/frame boundary; a new DATA write in the first IDLE cycle after STOP SHALL be accepted.

Reset
REQ-023 rst=1 SHALL immediately force address=0, fault=0, uart_txd=1, FSM=IDLE, counters=0, bus high-impedance.
REQ-024 Reset mid-frame SHALL abort transmission with txd=1; RAM contents SHALL NOT be reset.

Structure
REQ-025 Shared package SHALL hold UART_DATA_ADDR, UART_STAT_ADDR, RAM_BASE and the UART state enum.
REQ-026 UART transmitter SHALL be sub-module uart_tx (inputs start, byte; outputs txd, busy); decode, RAM and bus drive SHALL stay in mem_unit.

Verification
REQ-027 load 0x10, wr 0xDEADBEEF; load 0x10, rd -> bus=0xDEADBEEF same cycle, fault=0.
REQ-028 load 0x8000_0000, wr 0x000000A5, CLKS_PER_BIT=4 -> txd 0 (4 clk), then 1,0,1,0,0,1,0,1 (4 clk each), then 1; STATUS read=1 during frame, 0 after.
REQ-029 DATA write 0x55 while busy -> frame unchanged (still 0xA5 bits), no second frame.
REQ-030 load 0x12, rd -> bus=0, fault=1; wr 0x1 -> RAM[0x10] unchanged; fault stays 1 until rst.
REQ-031 rst asserted mid DATA state -> txd=1, STATUS=0 immediately; previously written RAM word 0x10 still reads 0xDEADBEEF.
REQ-032 load 0x20 and wr 0x77 same cycle with prior address 0x10 -> RAM[0x10]=0x77, RAM[0x20] unchanged; bus Z whenever mem_rd=0.

Source files
------------

// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: memory map constants and UART state encoding shared by mem_unit and uart_tx.
package mem_unit_pkg;
    localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
    localparam logic [31:0] UART_DATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h8000_0004;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/mem_unit_uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, with registered txd/busy outputs.
module uart_tx import mem_unit_pkg::*; #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       txd_o,
    output logic       busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    logic          bit_end;
    assign bit_end = cnt_q == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            txd_o   <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= START;
                    sh_q    <= byte_i;
                    txd_o   <= 1'b0;
                    busy_o  <= 1'b1;
                end
                START: if (bit_end) begin
                    state_q <= DATA;
                    txd_o   <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                end
                // sh_q[0] always holds the next bit to emit
                DATA: if (bit_end) begin
                    idx_q   <= idx_q + 1'b1;
                    txd_o   <= (idx_q == 3'd7) ? 1'b1 : sh_q[0];
                    sh_q    <= sh_q >> 1;
                    state_q <= (idx_q == 3'd7) ? STOP : DATA;
                end
                STOP: if (bit_end) begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/mem_unit.sv
// mem_unit: bus-attached word RAM plus memory-mapped UART transmitter,
// with address register, address decode and sticky misalignment fault.
module mem_unit import mem_unit_pkg::*; #(
    parameter int MEM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] bus,
    input  logic        mem_load,
    input  logic        mem_rd,
    input  logic        mem_wr,
    output logic        uart_txd,
    output logic        fault
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [31:0] addr_q;
    logic        fault_q;
    logic [31:0] ram_q [MEM_WORDS];
    logic [31:0] rdata;
    logic        mis, is_ram, is_data, is_stat, busy, start;
    assign mis     = addr_q[1:0] != 2'b00;
    assign is_ram  = (addr_q - RAM_BASE) < 32'(4 * MEM_WORDS);
    assign is_data = addr_q == UART_DATA_ADDR;
    assign is_stat = addr_q == UART_STAT_ADDR;
    assign rdata   = mis ? '0 : is_ram ? ram_q[addr_q[AW+1:2]] : is_stat ? {31'b0, busy} : '0;
    assign bus     = (mem_rd && !mem_wr && !rst) ? rdata : 'z;
    assign start   = mem_wr && !mis && is_data && !busy;
    assign fault   = fault_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            addr_q  <= mem_load ? bus : addr_q;
            fault_q <= fault_q | ((mem_rd | mem_wr) & mis);
        end
    end
    // RAM is deliberately outside the reset domain so contents survive rst
    always_ff @(posedge clk) begin
        if (mem_wr && !mis && is_ram) ram_q[addr_q[AW+1:2]] <= bus;
    end
    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .byte_i  (bus[7:0]),
        .txd_o   (uart_txd),
        .busy_o  (busy)
    );
endmodule
